// File: rtl/divider_32_pkg.sv
// Shared CPU package for the multi-cycle signed divider.
// Holds the FSM state encodings, the default width and the divide-by-zero quotient.
package divider_32_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_CORR = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/divider_32_add_sub.sv
// Combinational W-bit add/subtract: y = a + (b ^ {subtract}) + subtract.
// Ports: a, b operands; subtract selects a-b; y result (wraps modulo 2^W).
module div_add_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         subtract,
    output logic [W-1:0] y
);

    assign y = a + (b ^ {W{subtract}}) + {{(W-1){1'b0}}, subtract};

endmodule

// File: rtl/divider_32.sv
// Multi-cycle signed non-restoring divider, one add/subtract step per clock.
// Ports: clock, clear (async high); start/dividend/divisor in; busy, done, quotient, remainder, div_by_zero out.
module divider_32
    import divider_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_mag_q, dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_sub;
    logic [WIDTH:0]   add_y;
    logic [WIDTH:0]   p_fix;
    logic [WIDTH-1:0] r_mag;

    // Shared adder: shifted remainder during ITERATE, raw remainder for the
    // final fix-up in CORRECT (always an add there).
    assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign add_a   = (state_q == ST_CORR) ? p_q : p_shift;
    assign add_b   = {1'b0, dvs_mag_q};
    assign add_sub = (state_q == ST_ITER) && !p_q[WIDTH];

    div_add_sub #(
        .W (WIDTH + 1)
    ) u_add_sub (
        .a        (add_a),
        .b        (add_b),
        .subtract (add_sub),
        .y        (add_y)
    );

    assign p_fix = p_q[WIDTH] ? add_y : p_q;
    assign r_mag = p_fix[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        dvd_mag_d = dvd_mag_q;
        dvs_mag_d = dvs_mag_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        zero_d    = zero_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // |-2^(W-1)| wraps to itself, which is the correct unsigned magnitude.
                    dvd_neg_d = dividend[WIDTH-1];
                    dvs_neg_d = divisor[WIDTH-1];
                    dvd_mag_d = dividend[WIDTH-1] ? -dividend : dividend;
                    dvs_mag_d = divisor[WIDTH-1] ? -divisor : divisor;
                    zero_d    = (divisor == '0);
                    p_d       = '0;
                    q_d       = dividend[WIDTH-1] ? -dividend : dividend;
                    cnt_d     = '0;
                    state_d   = ST_ITER;
                end
            end
            ST_ITER: begin
                p_d   = add_y;
                q_d   = {q_q[WIDTH-2:0], ~add_y[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_CORR;
                end
            end
            ST_CORR: begin
                p_d    = p_fix;
                done_d = 1'b1;
                if (zero_q) begin
                    quo_d = DIV0_QUOT;
                    rem_d = dvd_neg_q ? -dvd_mag_q : dvd_mag_q;
                    dz_d  = 1'b1;
                end else begin
                    quo_d = (dvd_neg_q ^ dvs_neg_q) ? -q_q : q_q;
                    rem_d = dvd_neg_q ? -r_mag : r_mag;
                    dz_d  = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            p_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            dvd_mag_q <= '0;
            dvs_mag_q <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            dvd_mag_q <= dvd_mag_d;
            dvs_mag_q <= dvs_mag_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            zero_q    <= zero_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule
